simple_latch: RTL and testbench
===============================

// Module: simple_latch
// PURPOSE
//  - Load-enabled storage element with true and complement outputs.
//  - Captures DATA_W-bit `data` when `load` is high and holds it while `load` is low.
//  - Used as a generic hold/capture cell in control paths.
//  - Default build is a clocked flop with enable; the optional build adds a transparent bypass.
// PARAMETERS
//  - DATA_W     1   width of data/dout/t
//  - RST_VAL    0   DATA_W-bit value loaded into storage on reset
// PORTS
//  - clk    in   1        single clock; all state updates on rising edge
//  - rst_n  in   1        reset, asynchronous assert, active-low
//  - data   in   DATA_W   value to capture
//  - load   in   1        capture enable, active-high
//  - dout   out  DATA_W   stored (or bypassed) value
//  - t      out  DATA_W   bitwise complement of dout, always ~dout
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//  - State: one DATA_W register `q`.
//  - Reset: rst_n low -> q=RST_VAL immediately, with no clock needed.
//    - Outputs during reset: dout=RST_VAL, t=~RST_VAL (default dout=0, t=1).
//  - Reset release: rst_n deassertion takes effect on the next rising edge only; there is no glitch on dout.
//  - Capture: rising clk with load=1 -> q<=data; dout shows the new value 1 cycle later.
//  - Hold: rising clk with load=0 -> q unchanged, for any number of cycles.
//  - Reset vs. load: reset dominates. If rst_n is low, the load/data inputs are ignored.
//    - Reset mid-operation clears q in the same instant.
//  - t is purely combinational, t=~dout, with no extra latency. dout and t are never equal bitwise.
//  - Width rules: all DATA_W bits load together; there are no per-bit enables.
//  - X handling: load=X at an edge must not silently corrupt q in simulation; the model propagates X.
//  - No handshake and no backpressure; a capture is accepted every cycle load=1.
// CONFIGURATION
//  - Macro: SIMPLE_LATCH_TRANSPARENT_EN
//  - Undefined (default): dout=q, so dout is registered and has 1-cycle load latency.
//  - Defined: dout = load ? data : q.
//    - data passes to dout combinationally while load=1.
//    - q still captures on the clock edge as above.
//    - When load falls, dout holds the last value captured.
//    - In reset, dout=RST_VAL regardless of load.
//    - t=~dout in both builds.
// STRUCTURE
//  - Shared package simple_latch_pkg:
//    - localparam default width;
//    - RST_VAL default constant;
//    - typedef for the data word.
//  - Optional sub-module simple_latch_bit: one storage bit with async reset and enable, generated DATA_W times.
//  - Top-level mux for the transparent option and the complement output.
// TESTING
//  - Reset: rst_n=0 with data=1, load=1 -> dout=0, t=1 before any clk edge.
//  - Hold:
//    - after reset release, set data=0, load=0 for 2 edges -> dout=0, t=1;
//    - then data=1, load=0 -> dout stays 0.
//  - Load:
//    - data=0, load=1 for 1 edge -> dout=0, t=1;
//    - then data=1, load=1 for 1 edge -> dout=1, t=0.
//  - Hold after load: dout=1, then data=0, load=0 for 3 edges -> dout=1, t=0.
//  - Async reset mid-operation:
//    - with dout=1, pull rst_n low between edges -> dout=0, t=1 immediately;
//    - load=1 is ignored while reset is low.
//  - Transparent build (macro defined):
//    - load=1, data=1 -> dout=1 with no edge;
//    - drop load before an edge -> dout returns to q.

Source files
------------

// File: rtl/simple_latch_pkg.sv
// ---------------------------------------------------------------------------
// simple_latch_pkg
//   Shared constants and types for the simple_latch load-enabled storage cell.
//   - SIMPLE_LATCH_DATA_W  : default storage width
//   - SIMPLE_LATCH_RST_BIT : value every storage bit takes in reset
//   - simple_latch_word_t  : data word at the default width
// ---------------------------------------------------------------------------
package simple_latch_pkg;

    // Default width of data/dout/t.
    localparam int SIMPLE_LATCH_DATA_W = 1;

    // Reset value of a single storage bit. The default word reset value is
    // this bit replicated across the full width (all zeros).
    localparam logic SIMPLE_LATCH_RST_BIT = 1'b0;

    // Data word at the default width.
    typedef logic [SIMPLE_LATCH_DATA_W-1:0] simple_latch_word_t;

endpackage : simple_latch_pkg

// File: rtl/simple_latch_bit.sv
// ---------------------------------------------------------------------------
// simple_latch_bit
//   One storage bit with an asynchronous active-low reset and a capture enable.
//   Ports:
//     clk   in  1  clock, state updates on the rising edge
//     rst_n in  1  asynchronous, active-low reset (q -> RST_BIT at once)
//     d     in  1  value to capture
//     en    in  1  capture enable, active-high
//     q     out 1  stored value
// ---------------------------------------------------------------------------
module simple_latch_bit
    import simple_latch_pkg::*;
#(
    parameter logic RST_BIT = SIMPLE_LATCH_RST_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic en,
    output logic q
);

    logic r_q;

    // The ternary (rather than an if) makes an unknown enable merge d and the
    // old value, so an X on en shows up as X in simulation instead of being
    // silently treated as "hold".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_BIT;
        end else begin
            r_q <= en ? d : r_q;
        end
    end

    assign q = r_q;

endmodule : simple_latch_bit

// File: rtl/simple_latch.sv
// ---------------------------------------------------------------------------
// simple_latch
//   Load-enabled storage element with true and complement outputs. Captures
//   the DATA_W-bit data word on a rising clk while load is high and holds it
//   while load is low. All bits load together.
//
//   Parameters:
//     DATA_W   width of data/dout/t
//     RST_VAL  value held in storage during reset
//
//   Ports:
//     clk    in  1       clock, state updates on the rising edge
//     rst_n  in  1       asynchronous assert, active-low reset
//     data   in  DATA_W  value to capture
//     load   in  1       capture enable, active-high
//     dout   out DATA_W  stored (or bypassed) value
//     t      out DATA_W  bitwise complement of dout
//
//   Build option:
//     SIMPLE_LATCH_TRANSPARENT_EN undefined (default): dout is the stored
//       value, so a capture appears one cycle after the load edge.
//     SIMPLE_LATCH_TRANSPARENT_EN defined: while load is high data passes
//       straight to dout; storage still captures on the clock edge, and in
//       reset dout is RST_VAL regardless of load.
// ---------------------------------------------------------------------------
module simple_latch
    import simple_latch_pkg::*;
#(
    parameter int                DATA_W  = SIMPLE_LATCH_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{SIMPLE_LATCH_RST_BIT}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] t
);

    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_dout;

    // One storage bit per data bit; every bit shares the same enable so the
    // word always loads as a unit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            simple_latch_bit #(
                .RST_BIT (RST_VAL[gi])
            ) u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (data[gi]),
                .en    (load),
                .q     (w_q[gi])
            );
        end
    endgenerate

`ifdef SIMPLE_LATCH_TRANSPARENT_EN
    // The bypass must be gated by reset: storage already reads RST_VAL in
    // reset, but a high load would otherwise leak data through.
    always_comb begin
        w_dout = w_q;
        if (!rst_n) begin
            w_dout = RST_VAL;
        end else if (load) begin
            w_dout = data;
        end
    end
`else
    assign w_dout = w_q;
`endif

    assign dout = w_dout;
    assign t    = ~w_dout;

endmodule : simple_latch

// File: tb/tb_simple_latch.sv
// ---------------------------------------------------------------------------
// tb_simple_latch
//   Directed and randomized checks of simple_latch against a reference model
//   that tracks the stored word as a plain variable.
// ---------------------------------------------------------------------------
module tb_simple_latch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data;
    logic         load;
    logic [W-1:0] dout;
    logic [W-1:0] t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the word most recently captured since reset.
    logic [W-1:0] model_q;

    always #5 clk = ~clk;

    simple_latch #(
        .DATA_W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .load  (load),
        .dout  (dout),
        .t     (t)
    );

    // What dout should be right now, given the model and current inputs.
    function automatic logic [W-1:0] expected_dout();
        if (!rst_n) return '0;
`ifdef SIMPLE_LATCH_TRANSPARENT_EN
        if (load) return data;
`endif
        return model_q;
    endfunction

    task automatic check(input string tag);
        logic [W-1:0] exp_d;
        logic [W-1:0] exp_t;
        exp_d = expected_dout();
        exp_t = ~exp_d;
        n_checks++;
        assert (dout === exp_d) else begin
            n_fail++;
            $error("FAIL %s dout: observed=%h expected=%h", tag, dout, exp_d);
        end
        n_checks++;
        assert (t === exp_t) else begin
            n_fail++;
            $error("FAIL %s t: observed=%h expected=%h", tag, t, exp_t);
        end
        $display("check %-20s rst_n=%b load=%b data=%h dout=%h t=%h", tag, rst_n, load, data, dout, t);
    endtask

    // Wait for a rising edge, apply the capture rule to the model, then let
    // the DUT settle before anything is sampled.
    task automatic clock_edge();
        @(posedge clk);
        if (rst_n && load) model_q = data;
        #1;
    endtask

    task automatic assert_reset();
        rst_n   = 1'b0;
        model_q = '0;
    endtask

    initial begin
        // Reset held with load/data active, checked before the first edge.
        data  = 8'h01;
        load  = 1'b1;
        assert_reset();
        #1;
        check("reset_pre_edge");
        clock_edge();
        check("reset_ignores_load");
        clock_edge();

        // Hold after release.
        rst_n = 1'b1;
        data  = 8'h00;
        load  = 1'b0;
        clock_edge();
        clock_edge();
        check("hold_zero");
        data = 8'h01;
        #1;
        check("hold_data_change");
        clock_edge();
        check("hold_edge");

        // Loads.
        data = 8'h00;
        load = 1'b1;
        clock_edge();
        check("load_zero");
        data = 8'hA5;
        clock_edge();
        check("load_a5");

        // Hold after load for three edges.
        data = 8'h00;
        load = 1'b0;
        repeat (3) clock_edge();
        check("hold_after_load");

        // Async reset between edges; load ignored while low.
        #2;
        assert_reset();
        #1;
        check("async_reset");
        data = 8'hFF;
        load = 1'b1;
        clock_edge();
        check("async_reset_load_ign");
        load  = 1'b0;
        rst_n = 1'b1;
        clock_edge();
        check("release_no_glitch");

        // Bypass behaviour (in the default build dout stays on storage).
        data = 8'h5A;
        load = 1'b1;
        #1;
        check("bypass_load_high");
        load = 1'b0;
        #1;
        check("bypass_load_drop");
        clock_edge();
        check("bypass_after_edge");

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            data = W'($urandom);
            load = ($urandom_range(0, 2) == 0);
            #1;
            check("rand_comb");
            clock_edge();
            check("rand_edge");
            if ($urandom_range(0, 15) == 0) begin
                assert_reset();
                load = 1'b1;
                data = W'($urandom) | 8'h80;
                #1;
                check("rand_reset");
                clock_edge();
                check("rand_reset_edge");
                rst_n = 1'b1;
                load  = 1'b0;
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_simple_latch
